// File: rtl/mem_resp.sv
// mem_resp: system-bus memory responder with per-word parity.
// Answers OK/EN/PE after a fixed access delay, silent when unselected.
`timescale 1ns/1ps
module mem_resp #(
    parameter logic [3:0]  NB_SEL    = 4'd0,
    parameter int          AW        = 12,
    parameter logic [3:0]  ACC_TICKS = 4'd4,
    parameter logic [16:0] WP_LIMIT  = 17'd0
) (
    input  logic        __clk,
    input  logic        clo_,
    input  logic        dw_,
    input  logic        dr_,
    input  logic [3:0]  nb,
    input  logic [15:0] ad,
    input  logic [15:0] dt_i,
    input  logic        pe_inject,
    output logic [15:0] dt_o,
    output logic        dt_oe,
    output logic        rok_,
    output logic        ren_,
    output logic        rpe_
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, SILENT} state_t;

    localparam logic [3:0] LAST = ACC_TICKS - 4'd1;

    state_t        state, state_n;
    logic          dw_s1, dw_s2, dr_s1, dr_s2;
    logic [3:0]    cnt, cnt_n;
    logic [AW-1:0] a_q, a_n;
    logic [15:0]   d_q, d_n;
    logic          wr_q, wr_n;
    logic          deny_q, deny_n;
    logic [15:0]   dto_n;
    logic          oe_n, rok_n, ren_n, rpe_n;
    logic          mem_we;
    logic          req, both_lo, both_hi, sel, deny_now, par_w;
    logic [16:0]   rd_word;
    logic [16:0]   mem [0:(1<<AW)-1];

    always_ff @(posedge __clk or negedge clo_) begin
        if (!clo_) begin
            dw_s1 <= 1'b1;
            dw_s2 <= 1'b1;
            dr_s1 <= 1'b1;
            dr_s2 <= 1'b1;
        end else begin
            dw_s1 <= dw_;
            dw_s2 <= dw_s1;
            dr_s1 <= dr_;
            dr_s2 <= dr_s1;
        end
    end

    assign req      = dw_s2 ^ dr_s2;
    assign both_lo  = ~dw_s2 & ~dr_s2;
    assign both_hi  = dw_s2 & dr_s2;
    assign sel      = (nb == NB_SEL) && ({1'b0, ad} < (17'd1 << AW));
    assign deny_now = ~dw_s2 && ({1'b0, ad} < WP_LIMIT);
    // Stored parity makes the 17-bit word odd unless corruption is injected.
    assign par_w    = ~(^d_q) ^ pe_inject;
    assign rd_word  = mem[a_q];

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        a_n     = a_q;
        d_n     = d_q;
        wr_n    = wr_q;
        deny_n  = deny_q;
        dto_n   = dt_o;
        oe_n    = dt_oe;
        rok_n   = rok_;
        ren_n   = ren_;
        rpe_n   = rpe_;
        mem_we  = 1'b0;
        unique case (state)
            IDLE: begin
                if (req && sel) begin
                    state_n = ACCESS;
                    cnt_n   = 4'd0;
                    a_n     = ad[AW-1:0];
                    d_n     = dt_i;
                    wr_n    = ~dw_s2;
                    deny_n  = deny_now;
                end else if (req || both_lo) begin
                    state_n = SILENT;
                end
            end
            ACCESS: begin
                if (cnt == LAST) begin
                    state_n = RESP;
                    if (wr_q) begin
                        if (deny_q) begin
                            ren_n = 1'b0;
                        end else begin
                            mem_we = 1'b1;
                            rok_n  = 1'b0;
                        end
                    end else begin
                        dto_n = rd_word[15:0];
                        oe_n  = 1'b1;
                        if (^rd_word) rok_n = 1'b0;
                        else          rpe_n = 1'b0;
                    end
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            RESP: begin
                if (both_hi) begin
                    state_n = IDLE;
                    dto_n   = 16'h0000;
                    oe_n    = 1'b0;
                    rok_n   = 1'b1;
                    ren_n   = 1'b1;
                    rpe_n   = 1'b1;
                end
            end
            SILENT: begin
                if (both_hi) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge __clk or negedge clo_) begin
        if (!clo_) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            a_q    <= '0;
            d_q    <= 16'h0000;
            wr_q   <= 1'b0;
            deny_q <= 1'b0;
            dt_o   <= 16'h0000;
            dt_oe  <= 1'b0;
            rok_   <= 1'b1;
            ren_   <= 1'b1;
            rpe_   <= 1'b1;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            a_q    <= a_n;
            d_q    <= d_n;
            wr_q   <= wr_n;
            deny_q <= deny_n;
            dt_o   <= dto_n;
            dt_oe  <= oe_n;
            rok_   <= rok_n;
            ren_   <= ren_n;
            rpe_   <= rpe_n;
        end
    end

    // Array has no reset; only the FSM gates writes, so clo_ drops them.
    always_ff @(posedge __clk) begin
        if (mem_we) mem[a_q] <= {par_w, d_q};
    end

endmodule

// File: tb/tb_mem_resp.sv
// Directed bench for mem_resp: two responders on one bus,
// block 0 unprotected, block 1 with low-memory write denial.
`timescale 1ns/1ps
module tb_mem_resp;

    localparam logic [2:0] R_OK   = 3'b011;
    localparam logic [2:0] R_EN   = 3'b101;
    localparam logic [2:0] R_PE   = 3'b110;
    localparam logic [2:0] R_NONE = 3'b111;

    typedef struct {
        logic [2:0]  r;
        logic [15:0] d;
        logic        oe;
    } exp_t;

    logic        clk = 1'b0;
    logic        clo_ = 1'b0;
    logic        dw_ = 1'b1;
    logic        dr_ = 1'b1;
    logic [3:0]  nb = 4'd0;
    logic [15:0] ad = 16'h0;
    logic [15:0] dt_i = 16'h0;
    logic        pe_inject = 1'b0;

    logic [15:0] dt_o0, dt_o1;
    logic        oe0, oe1, rok0, rok1, ren0, ren1, rpe0, rpe1;

    int checks = 0;
    int errors = 0;

    exp_t        sb [$];
    logic [15:0] mdl  [logic [19:0]];
    bit          mbad [logic [19:0]];

    always #10 clk = ~clk;

    mem_resp #(.NB_SEL(4'd0), .AW(12), .ACC_TICKS(4'd4), .WP_LIMIT(17'd0)) u_dut0 (
        .__clk(clk), .clo_(clo_), .dw_(dw_), .dr_(dr_), .nb(nb), .ad(ad),
        .dt_i(dt_i), .pe_inject(pe_inject), .dt_o(dt_o0), .dt_oe(oe0),
        .rok_(rok0), .ren_(ren0), .rpe_(rpe0)
    );

    mem_resp #(.NB_SEL(4'd1), .AW(12), .ACC_TICKS(4'd4), .WP_LIMIT(17'd256)) u_dut1 (
        .__clk(clk), .clo_(clo_), .dw_(dw_), .dr_(dr_), .nb(nb), .ad(ad),
        .dt_i(dt_i), .pe_inject(pe_inject), .dt_o(dt_o1), .dt_oe(oe1),
        .rok_(rok1), .ren_(ren1), .rpe_(rpe1)
    );

    function automatic logic [2:0] resp(input bit t);
        return t ? {rok1, ren1, rpe1} : {rok0, ren0, rpe0};
    endfunction

    function automatic logic [15:0] dto(input bit t);
        return t ? dt_o1 : dt_o0;
    endfunction

    function automatic logic oe(input bit t);
        return t ? oe1 : oe0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_cmp(input bit t);
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 1, 0);
        end else begin
            e = sb.pop_front();
            check("resp_code", resp(t), e.r);
            check("dt_o", dto(t), e.d);
            check("dt_oe", oe(t), e.oe);
        end
    endtask

    task automatic xfer(input bit wr, input logic [3:0] n,
                        input logic [15:0] a, input logic [15:0] d,
                        input bit pe, input bit chk,
                        output logic [2:0] r_obs, output logic [15:0] d_obs);
        int k;
        bit t;
        t = (n == 4'd1);
        @(negedge clk);
        nb = n; ad = a; dt_i = d; pe_inject = pe;
        if (wr) dw_ = 1'b0;
        else    dr_ = 1'b0;
        k = 0;
        do begin tick(); k++; end while (resp(t) == R_NONE && k < 20);
        check("resp_latency", k, 7);
        r_obs = resp(t);
        d_obs = dto(t);
        if (chk) pop_cmp(t);
        @(negedge clk);
        dw_ = 1'b1; dr_ = 1'b1;
        k = 0;
        do begin tick(); k++; end while (resp(t) != R_NONE && k < 20);
        check("release_latency", k, 3);
        check("release_oe_do", {oe(t), dto(t)}, 17'h0);
    endtask

    task automatic wr_op(input logic [3:0] n, input logic [15:0] a,
                         input logic [15:0] d, input bit pe);
        exp_t e;
        logic [2:0] r;
        logic [15:0] x;
        e.d = 16'h0;
        e.oe = 1'b0;
        if (n == 4'd1 && a < 16'd256) begin
            e.r = R_EN;
        end else begin
            e.r = R_OK;
            mdl[{n, a}]  = d;
            mbad[{n, a}] = pe;
        end
        sb.push_back(e);
        xfer(1'b1, n, a, d, pe, 1'b1, r, x);
    endtask

    task automatic rd_op(input logic [3:0] n, input logic [15:0] a);
        exp_t e;
        logic [2:0] r;
        logic [15:0] x;
        e.r  = mbad[{n, a}] ? R_PE : R_OK;
        e.d  = mdl[{n, a}];
        e.oe = 1'b1;
        sb.push_back(e);
        xfer(1'b0, n, a, 16'h0, 1'b0, 1'b1, r, x);
    endtask

    task automatic silent(input string tag, input logic [3:0] n,
                          input logic [15:0] a, input bit w, input bit r);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        nb = n; ad = a;
        dw_ = ~w; dr_ = ~r;
        repeat (500) begin
            tick();
            if (resp(0) != R_NONE || resp(1) != R_NONE || oe0 || oe1)
                seen = 1'b1;
        end
        check(tag, seen, 0);
        @(negedge clk);
        dw_ = 1'b1; dr_ = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  r0;
        logic [15:0] d0;
        int k, w;

        repeat (3) tick();
        check("reset_dut0", {rok0, ren0, rpe0, oe0, dt_o0}, {R_NONE, 1'b0, 16'h0});
        check("reset_dut1", {rok1, ren1, rpe1, oe1, dt_o1}, {R_NONE, 1'b0, 16'h0});
        @(negedge clk);
        clo_ = 1'b1;
        repeat (2) tick();

        wr_op(4'd0, 16'h0123, 16'hA5C3, 1'b0);
        rd_op(4'd0, 16'h0123);

        wr_op(4'd0, 16'h0200, 16'h0001, 1'b1);
        rd_op(4'd0, 16'h0200);
        wr_op(4'd0, 16'h0200, 16'h0001, 1'b0);
        rd_op(4'd0, 16'h0200);

        // Denied word's content is whatever the array holds; learn it first.
        xfer(1'b0, 4'd1, 16'h00FF, 16'h0, 1'b0, 1'b0, r0, d0);
        check("learn_code", (r0 == R_OK || r0 == R_PE), 1);
        wr_op(4'd1, 16'h00FF, ~d0, 1'b0);
        mdl[{4'd1, 16'h00FF}]  = d0;
        mbad[{4'd1, 16'h00FF}] = (r0 == R_PE);
        rd_op(4'd1, 16'h00FF);
        wr_op(4'd1, 16'h0100, 16'hBEEF, 1'b0);
        rd_op(4'd1, 16'h0100);

        silent("silent_nb3", 4'd3, 16'h0123, 1'b0, 1'b1);
        silent("silent_ad1000", 4'd0, 16'h1000, 1'b1, 1'b0);
        silent("silent_overlap", 4'd0, 16'h0123, 1'b1, 1'b1);
        rd_op(4'd0, 16'h0123);

        wr_op(4'd0, 16'h0042, 16'h1111, 1'b0);
        @(negedge clk);
        nb = 4'd0; ad = 16'h0042; dt_i = 16'h2222; dw_ = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        clo_ = 1'b0;
        #1;
        check("rst_access", {rok0, ren0, rpe0, oe0, dt_o0}, {R_NONE, 1'b0, 16'h0});
        dw_ = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        clo_ = 1'b1;
        repeat (2) tick();
        rd_op(4'd0, 16'h0042);

        @(negedge clk);
        nb = 4'd0; ad = 16'h0123; dr_ = 1'b0;
        repeat (7) tick();
        check("rst_resp_pre", {rok0, oe0, dt_o0}, {1'b0, 1'b1, 16'hA5C3});
        @(negedge clk);
        clo_ = 1'b0;
        #1;
        check("rst_resp", {rok0, ren0, rpe0, oe0, dt_o0}, {R_NONE, 1'b0, 16'h0});
        dr_ = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        clo_ = 1'b1;
        repeat (2) tick();

        sb.push_back('{r: R_OK, d: 16'hA5C3, oe: 1'b1});
        @(negedge clk);
        nb = 4'd0; ad = 16'h0123; dr_ = 1'b0;
        k = 0;
        repeat (4) begin tick(); k++; end
        @(negedge clk);
        dr_ = 1'b1;
        do begin tick(); k++; end while (resp(0) == R_NONE && k < 20);
        check("ew_latency", k, 7);
        pop_cmp(1'b0);
        w = 0;
        while (resp(0) != R_NONE && w < 20) begin tick(); w++; end
        check("ew_width", w, 1);
        check("ew_release_oe", oe0, 0);
        repeat (3) tick();
        rd_op(4'd0, 16'h0123);

        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
